uart_rx_byte: RTL and testbench

// - Serial receive front end feeding the command processor: recovers 8N1 UART bytes from the async rx pin.
// - Presents each byte as rxData plus a one-cycle rxReady strobe, the exact pair the processor samples in its READ/READMORE states.
// - Adds a 2-FF synchronizer, false-start rejection, 3-sample majority voting, and framing-error detection with break handling.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_byte.sv | 143 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive path (and the future transmitter).
//   uart_state_e      : receiver FSM states
//   UART_DATA_BITS    : payload bits per frame (8N1)
//   UART_CLKS_PER_BIT : default bit period in clk cycles (50 MHz / 115200)
//   maj3()            : 2-of-3 majority used for mid-bit voting
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        HUNT,
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, loads RESET_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output (two cycles of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= RESET_VAL;
            q  <= RESET_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver front end for the command processor.
//   clk          : system clock
//   rst_n        : synchronous active-low reset
//   rx           : asynchronous serial line, idles high
//   rxData       : last correctly framed byte (LSB received first)
//   rxReady      : one-cycle strobe, rxData is new this cycle
//   rx_frame_err : one-cycle strobe, stop bit sampled low
//   rx_active    : high while a frame is being received (START/DATA/STOP)
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rxData,
    output logic                      rxReady,
    output logic                      rx_frame_err,
    output logic                      rx_active
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW   = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(HALF);
    localparam logic [CW-1:0] CNT_VOTE  = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_HUNT  = CW'(2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

    uart_state_e               state;
    logic                      rx_s;
    logic                      rx_s_d;
    logic [CW-1:0]             cnt;
    logic [BW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] sr;
    logic                      smp_a;
    logic                      smp_b;
    logic                      vote;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Third sample is the live rx_s at cnt == HALF+1.
    assign vote = maj3(smp_a, smp_b, rx_s);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= HUNT;
            rx_s_d       <= 1'b1;
            cnt          <= '0;
            bit_idx      <= '0;
            sr           <= '0;
            smp_a        <= 1'b1;
            smp_b        <= 1'b1;
            rxData       <= '0;
            rxReady      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_active    <= 1'b0;
        end else begin
            rx_s_d       <= rx_s;
            rxReady      <= 1'b0;
            rx_frame_err <= 1'b0;
            cnt          <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

            if (cnt == CNT_PRE) smp_a <= rx_s;
            if (cnt == CNT_MID) smp_b <= rx_s;

            case (state)
                // The synchronizer flops come out of reset high, so the first
                // two rx_s values after reset are not the real line. Require
                // three consecutive high samples before trusting the line idle.
                HUNT: begin
                    if (!rx_s) begin
                        cnt <= '0;
                    end else if (cnt == CNT_HUNT) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end

                IDLE: begin
                    cnt <= '0;
                    if (rx_s_d && !rx_s) begin
                        state     <= START;
                        rx_active <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_VOTE && vote) begin
                        state     <= IDLE;
                        rx_active <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end

                DATA: begin
                    if (cnt == CNT_VOTE) sr <= {vote, sr[UART_DATA_BITS-1:1]};
                    if (cnt == CNT_LAST) begin
                        if (bit_idx == BIT_LAST) state <= STOP;
                        else                     bit_idx <= bit_idx + 1'b1;
                    end
                end

                // Decide at mid stop bit so the next start edge is not missed.
                STOP: begin
                    if (cnt == CNT_VOTE) begin
                        cnt       <= '0;
                        rx_active <= 1'b0;
                        if (vote) begin
                            rxData  <= sr;
                            rxReady <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= HUNT;
                        end
                    end
                end

                default: begin
                    state     <= HUNT;
                    cnt       <= '0;
                    rx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rxData;
    logic       rxReady;
    logic       rx_frame_err;
    logic       rx_active;

    int cmp_count = 0;
    int err_count = 0;

    int cyc      = 0;
    int n_ready  = 0;
    int n_err    = 0;
    int n_both   = 0;
    int n_active = 0;
    int last_rdy = 0;
    int prev_rdy = 0;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rxData       (rxData),
        .rxReady      (rxReady),
        .rx_frame_err (rx_frame_err),
        .rx_active    (rx_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (rxReady) begin
            n_ready  = n_ready + 1;
            prev_rdy = last_rdy;
            last_rdy = cyc;
        end
        if (rx_frame_err)            n_err    = n_err + 1;
        if (rxReady && rx_frame_err) n_both   = n_both + 1;
        if (rx_active)               n_active = n_active + 1;
    end

    task automatic clear_counts();
        n_ready  = 0;
        n_err    = 0;
        n_both   = 0;
        n_active = 0;
    endtask

    task automatic idle(input int n, input logic lvl);
        repeat (n) begin
            @(posedge clk); #2;
            rx = lvl;
        end
    endtask

    // Frame bit f: 0 = start, 1..8 = data, 9 = stop. Pin changes 2 units after
    // the edge. gbit/gcyc invert the pin for one cycle; rbit pulses reset at
    // cycle 4 of that frame bit. launch = monitor cycle of the start-bit edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_lvl,
                             input int gbit, input int gcyc, input int rbit,
                             output int launch);
        logic lvl;
        launch = 0;
        for (int f = 0; f < 10; f++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                @(posedge clk); #2;
                if (f == 0)      lvl = 1'b0;
                else if (f == 9) lvl = stop_lvl;
                else             lvl = b[f-1];
                if (f == gbit && c == gcyc) lvl = ~lvl;
                rx    = lvl;
                rst_n = !(f == rbit && c == 4);
                if (f == 0 && c == 0) launch = cyc;
            end
        end
    endtask

    task automatic test_reset();
        int l;
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        cmp_count++;
        if (rxData !== 8'h00) begin
            err_count++;
            $display("FAIL reset_rxData: got %h want 00", rxData);
        end
        cmp_count++;
        if ({rxReady, rx_frame_err, rx_active} !== 3'b000) begin
            err_count++;
            $display("FAIL reset_strobes: got %b want 000", {rxReady, rx_frame_err, rx_active});
        end
        rst_n = 1'b1;
        clear_counts();
        idle(100, 1'b0);
        cmp_count++;
        if (n_ready + n_err + n_active !== 0) begin
            err_count++;
            $display("FAIL low_after_reset: ready=%0d err=%0d active=%0d want all 0",
                     n_ready, n_err, n_active);
        end
        idle(20, 1'b1);
        clear_counts();
        send_byte(8'h55, 1'b1, -1, -1, -1, l);
        cmp_count++;
        if (rxData !== 8'h55 || n_ready !== 1) begin
            err_count++;
            $display("FAIL first_byte: got %h x%0d want 55 x1", rxData, n_ready);
        end
        cmp_count++;
        if (last_rdy - l !== 157) begin
            err_count++;
            $display("FAIL latency: got %0d want 157", last_rdy - l);
        end
    endtask

    task automatic test_back_to_back();
        int l;
        idle(20, 1'b1);
        clear_counts();
        send_byte(8'hA5, 1'b1, -1, -1, -1, l);
        cmp_count++;
        if (rxData !== 8'hA5) begin
            err_count++;
            $display("FAIL b2b_first: got %h want a5", rxData);
        end
        send_byte(8'h3C, 1'b1, -1, -1, -1, l);
        cmp_count++;
        if (rxData !== 8'h3C || n_ready !== 2) begin
            err_count++;
            $display("FAIL b2b_second: got %h x%0d want 3c x2", rxData, n_ready);
        end
        cmp_count++;
        if (last_rdy - prev_rdy !== 160) begin
            err_count++;
            $display("FAIL b2b_spacing: got %0d want 160", last_rdy - prev_rdy);
        end
    endtask

    task automatic test_glitch();
        idle(20, 1'b1);
        clear_counts();
        idle(4, 1'b0);
        idle(40, 1'b1);
        cmp_count++;
        if (n_active !== 10) begin
            err_count++;
            $display("FAIL glitch_active: got %0d cycles want 10", n_active);
        end
        cmp_count++;
        if (n_ready !== 0 || n_err !== 0 || rxData !== 8'h3C) begin
            err_count++;
            $display("FAIL glitch_quiet: ready=%0d err=%0d data=%h want 0 0 3c",
                     n_ready, n_err, rxData);
        end
    endtask

    task automatic test_break();
        int l;
        idle(20, 1'b1);
        clear_counts();
        send_byte(8'h00, 1'b0, -1, -1, -1, l);
        cmp_count++;
        if (n_err !== 1 || n_ready !== 0 || rxData !== 8'h3C) begin
            err_count++;
            $display("FAIL frame_err: err=%0d ready=%0d data=%h want 1 0 3c",
                     n_err, n_ready, rxData);
        end
        n_active = 0;
        idle(40 * CPB, 1'b0);
        cmp_count++;
        if (n_active !== 0 || n_err !== 1 || n_ready !== 0) begin
            err_count++;
            $display("FAIL break_hunt: active=%0d err=%0d ready=%0d want 0 1 0",
                     n_active, n_err, n_ready);
        end
        idle(20, 1'b1);
        clear_counts();
        send_byte(8'h7E, 1'b1, -1, -1, -1, l);
        cmp_count++;
        if (rxData !== 8'h7E || n_ready !== 1 || n_err !== 0) begin
            err_count++;
            $display("FAIL after_break: got %h ready=%0d err=%0d want 7e 1 0",
                     rxData, n_ready, n_err);
        end
    endtask

    task automatic test_majority();
        int l;
        idle(20, 1'b1);
        clear_counts();
        // Frame bit 3 = data bit 2; pin cycle 9 lands on rx_s at cnt == HALF.
        send_byte(8'hF0, 1'b1, 3, 9, -1, l);
        cmp_count++;
        if (rxData !== 8'hF0 || n_ready !== 1) begin
            err_count++;
            $display("FAIL majority: got %h x%0d want f0 x1", rxData, n_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        int l;
        idle(20, 1'b1);
        clear_counts();
        send_byte(8'hC3, 1'b1, -1, -1, 5, l);
        idle(40, 1'b1);
        cmp_count++;
        if (n_ready !== 0 || n_err !== 0 || rxData !== 8'h00) begin
            err_count++;
            $display("FAIL reset_abort: ready=%0d err=%0d data=%h want 0 0 00",
                     n_ready, n_err, rxData);
        end
        clear_counts();
        send_byte(8'h81, 1'b1, -1, -1, -1, l);
        cmp_count++;
        if (rxData !== 8'h81 || n_ready !== 1) begin
            err_count++;
            $display("FAIL after_reset: got %h x%0d want 81 x1", rxData, n_ready);
        end
    endtask

    int both_total = 0;

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        test_reset();
        both_total += n_both;
        test_back_to_back();
        both_total += n_both;
        test_glitch();
        both_total += n_both;
        test_break();
        both_total += n_both;
        test_majority();
        both_total += n_both;
        test_reset_mid_frame();
        both_total += n_both;
        cmp_count++;
        if (both_total !== 0) begin
            err_count++;
            $display("FAIL strobe_overlap: got %0d cycles want 0", both_total);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
